rtc_controller: RTL and testbench

RTC_CONTROLLER -- requirements
Module: rtc_controller

---
 rtl/rtc_pkg.sv | 26 ++
 rtl/rtc_tick_gen.sv | 48 ++++
 rtl/rtc_controller.sv | 157 +++++++++++++++
 tb/tb_rtc_controller.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_pkg.sv
// ----------------------------------------------------------------------------
// rtc_pkg
// Shared types and constants for the real-time-clock controller.
//   rtc_state_e : set-mode FSM state encoding (RUN=0, SET_HR=1, SET_MIN=2)
//   HR_MAX / MIN_MAX / SEC_MAX : last legal value of each time field
//   *_W : field widths
// Optional feature macro used by rtc_controller: RTC_CONTROLLER_ALARM_EN
// ----------------------------------------------------------------------------
package rtc_pkg;

    localparam int unsigned HR_W    = 5;
    localparam int unsigned MIN_W   = 6;
    localparam int unsigned SEC_W   = 6;
    localparam int unsigned STATE_W = 2;

    localparam logic [HR_W-1:0]  HR_MAX  = 5'd23;
    localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;
    localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;

    typedef enum logic [STATE_W-1:0] {
        StRun    = 2'd0,
        StSetHr  = 2'd1,
        StSetMin = 2'd2
    } rtc_state_e;

endpackage

// File: rtl/rtc_tick_gen.sv
// ----------------------------------------------------------------------------
// rtc_tick_gen
// Prescaler producing a one-cycle registered tick every CLK_DIV clocks.
// Ports:
//   iclk : clock (posedge)
//   rst  : synchronous active-high reset
//   hold : while high, count is forced to 0 and tick stays low
//   tick : high for exactly the one cycle in which the count equals CLK_DIV-1
// Parameter:
//   CLK_DIV : tick period in iclk cycles, 2..65536
// ----------------------------------------------------------------------------
module rtc_tick_gen #(
    parameter int unsigned CLK_DIV = 25
) (
    input  logic iclk,
    input  logic rst,
    input  logic hold,
    output logic tick
);

    localparam int unsigned     CntW   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

    logic [CntW-1:0] r_cnt;
    logic [CntW-1:0] w_cnt_next;
    logic            r_tick;

    always_comb begin
        w_cnt_next = r_cnt + CntW'(1);
        if (hold || (r_cnt == CntMax)) begin
            w_cnt_next = '0;
        end
    end

    // tick is registered from the next count so it lines up with count==CLK_DIV-1
    always_ff @(posedge iclk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_next;
            r_tick <= !hold && (w_cnt_next == CntMax);
        end
    end

    assign tick = r_tick;

endmodule

// File: rtl/rtc_controller.sv
// ----------------------------------------------------------------------------
// rtc_controller
// 24-hour HH:MM:SS clock with a button-driven set mode.
// Ports:
//   iclk     : clock (posedge)
//   rst      : synchronous active-high reset
//   mode_btn : one-cycle pulse, cycles RUN -> SET_HR -> SET_MIN -> RUN
//   inc_btn  : one-cycle pulse, increments the field being set
//   hr/min/sec : current time
//   state    : FSM state (RUN=0, SET_HR=1, SET_MIN=2)
//   tick     : registered one-cycle 1 s pulse
// Optional (macro RTC_CONTROLLER_ALARM_EN):
//   alarm_hr, alarm_min, alarm_arm : alarm time and enable
//   alarm    : registered one-cycle pulse when running time reaches HH:MM:00
// Parameter:
//   CLK_DIV : iclk cycles per second, 2..65536
// ----------------------------------------------------------------------------
module rtc_controller #(
    parameter int unsigned CLK_DIV = 25
) (
    input  logic       iclk,
    input  logic       rst,
    input  logic       mode_btn,
    input  logic       inc_btn,
    output logic [4:0] hr,
    output logic [5:0] min,
    output logic [5:0] sec,
    output logic [1:0] state,
    output logic       tick
`ifdef RTC_CONTROLLER_ALARM_EN
    ,
    input  logic [4:0] alarm_hr,
    input  logic [5:0] alarm_min,
    input  logic       alarm_arm,
    output logic       alarm
`endif
);

    import rtc_pkg::*;

    rtc_state_e       r_state, w_state_next;
    logic [HR_W-1:0]  r_hr, w_hr_next;
    logic [MIN_W-1:0] r_min, w_min_next;
    logic [SEC_W-1:0] r_sec, w_sec_next;
    logic             w_tick;
    logic             w_hold;
    logic             w_advance;

    // Hold also on the mode press itself: entering set mode must not leave a
    // tick behind, and leaving it must restart the prescaler from exactly 0.
    assign w_hold = (r_state != StRun) || mode_btn;

    rtc_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .iclk (iclk),
        .rst  (rst),
        .hold (w_hold),
        .tick (w_tick)
    );

    assign w_advance = (r_state == StRun) && w_tick;

    always_comb begin
        w_state_next = r_state;
        if (mode_btn) begin
            unique case (r_state)
                StRun:    w_state_next = StSetHr;
                StSetHr:  w_state_next = StSetMin;
                StSetMin: w_state_next = StRun;
                default:  w_state_next = StRun;
            endcase
        end
    end

    always_comb begin
        w_hr_next  = r_hr;
        w_min_next = r_min;
        w_sec_next = r_sec;
        unique case (r_state)
            StRun: begin
                if (w_tick) begin
                    if (r_sec >= SEC_MAX) begin
                        w_sec_next = '0;
                        if (r_min >= MIN_MAX) begin
                            w_min_next = '0;
                            w_hr_next  = (r_hr >= HR_MAX) ? '0 : r_hr + HR_W'(1);
                        end else begin
                            w_min_next = r_min + MIN_W'(1);
                        end
                    end else begin
                        w_sec_next = r_sec + SEC_W'(1);
                    end
                end
            end
            StSetHr: begin
                // mode_btn wins over a coincident inc_btn
                if (inc_btn && !mode_btn) begin
                    w_hr_next = (r_hr >= HR_MAX) ? '0 : r_hr + HR_W'(1);
                end
            end
            StSetMin: begin
                if (mode_btn) begin
                    w_sec_next = '0;
                end else if (inc_btn) begin
                    w_min_next = (r_min >= MIN_MAX) ? '0 : r_min + MIN_W'(1);
                end
            end
            default: begin
                w_hr_next  = r_hr;
                w_min_next = r_min;
                w_sec_next = r_sec;
            end
        endcase
    end

    always_ff @(posedge iclk) begin
        if (rst) begin
            r_state <= StRun;
            r_hr    <= '0;
            r_min   <= '0;
            r_sec   <= '0;
        end else begin
            r_state <= w_state_next;
            r_hr    <= w_hr_next;
            r_min   <= w_min_next;
            r_sec   <= w_sec_next;
        end
    end

`ifdef RTC_CONTROLLER_ALARM_EN
    logic r_alarm;

    // Only a running-time advance can fire; values loaded in set mode cannot.
    always_ff @(posedge iclk) begin
        if (rst) begin
            r_alarm <= 1'b0;
        end else begin
            r_alarm <= alarm_arm && w_advance && (w_hr_next == alarm_hr) &&
                       (w_min_next == alarm_min) && (w_sec_next == '0);
        end
    end

    assign alarm = r_alarm;
`else
    // Default build: no alarm state; w_advance only feeds the alarm path.
    logic w_unused;
    assign w_unused = w_advance;
`endif

    assign hr    = r_hr;
    assign min   = r_min;
    assign sec   = r_sec;
    assign state = r_state;
    assign tick  = w_tick;

endmodule

// File: tb/tb_rtc_controller.sv
// Directed bench for rtc_controller (CLK_DIV=25).
// Cycle n after reset release is the clock period following the (n-1)-th
// posedge after the last reset edge; outputs are sampled 1 time unit after
// each posedge.
module tb_rtc_controller;

    localparam int unsigned CLK_DIV = 25;

    logic       iclk = 1'b0;
    logic       rst = 1'b1;
    logic       mode_btn = 1'b0;
    logic       inc_btn = 1'b0;
    logic [4:0] hr;
    logic [5:0] min;
    logic [5:0] sec;
    logic [1:0] state;
    logic       tick;
`ifdef RTC_CONTROLLER_ALARM_EN
    logic [4:0] alarm_hr = 5'd0;
    logic [5:0] alarm_min = 6'd0;
    logic       alarm_arm = 1'b0;
    logic       alarm;
`endif

    int n_vec = 0;
    int n_err = 0;

    rtc_controller #(
        .CLK_DIV (CLK_DIV)
    ) dut (
        .iclk     (iclk),
        .rst      (rst),
        .mode_btn (mode_btn),
        .inc_btn  (inc_btn),
        .hr       (hr),
        .min      (min),
        .sec      (sec),
        .state    (state),
        .tick     (tick)
`ifdef RTC_CONTROLLER_ALARM_EN
        ,
        .alarm_hr  (alarm_hr),
        .alarm_min (alarm_min),
        .alarm_arm (alarm_arm),
        .alarm     (alarm)
`endif
    );

    always #5 iclk = ~iclk;

    task automatic step();
        @(posedge iclk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        mode_btn = 1'b0;
        inc_btn  = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic press_mode();
        mode_btn = 1'b1;
        step();
        mode_btn = 1'b0;
    endtask

    task automatic press_inc();
        inc_btn = 1'b1;
        step();
        inc_btn = 1'b0;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if ({state, hr, min, sec, tick} !== 20'd0) begin
            n_err++;
            $display("FAIL reset_values: got st=%0d %0d:%0d:%0d tick=%0b expected all 0",
                     state, hr, min, sec, tick);
        end
        // Reset must beat a coincident tick
        repeat (24) step();
        n_vec++;
        if (tick !== 1'b1) begin
            n_err++;
            $display("FAIL reset_pre_tick: got tick=%0b expected 1", tick);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_vec++;
        if ({tick, sec} !== 7'd0) begin
            n_err++;
            $display("FAIL reset_vs_tick: got tick=%0b sec=%0d expected 0/0", tick, sec);
        end
    endtask

    task automatic test_tick_period();
        logic exp_tick;
        do_reset();
        for (int k = 1; k <= 100; k++) begin
            step();
            exp_tick = ((k % 25) == 24);
            n_vec++;
            if (tick !== exp_tick) begin
                n_err++;
                $display("FAIL tick_period: edge %0d got tick=%0b expected %0b", k, tick, exp_tick);
            end
            if (k == 25) begin
                n_vec++;
                if (sec !== 6'd1) begin
                    n_err++;
                    $display("FAIL first_sec: got sec=%0d expected 1", sec);
                end
            end
        end
        n_vec++;
        if (sec !== 6'd4) begin
            n_err++;
            $display("FAIL sec_after_100: got sec=%0d expected 4", sec);
        end
    endtask

    task automatic test_rollover();
        do_reset();
        press_mode();
        repeat (23) press_inc();
        press_mode();
        repeat (59) press_inc();
        press_mode();
        n_vec++;
        if ({state, hr, min, sec} !== {2'd0, 5'd23, 6'd59, 6'd0}) begin
            n_err++;
            $display("FAIL set_2359: got st=%0d %0d:%0d:%0d expected 0 23:59:0",
                     state, hr, min, sec);
        end
        repeat (58 * CLK_DIV) step();
        n_vec++;
        if ({hr, min, sec} !== {5'd23, 6'd59, 6'd58}) begin
            n_err++;
            $display("FAIL time_235958: got %0d:%0d:%0d expected 23:59:58", hr, min, sec);
        end
        repeat (CLK_DIV) step();
        n_vec++;
        if ({hr, min, sec} !== {5'd23, 6'd59, 6'd59}) begin
            n_err++;
            $display("FAIL time_235959: got %0d:%0d:%0d expected 23:59:59", hr, min, sec);
        end
        repeat (CLK_DIV - 1) step();
        n_vec++;
        if ({tick, hr, min, sec} !== {1'b1, 5'd23, 6'd59, 6'd59}) begin
            n_err++;
            $display("FAIL pre_midnight: got tick=%0b %0d:%0d:%0d expected 1 23:59:59",
                     tick, hr, min, sec);
        end
        step();
        n_vec++;
        if ({hr, min, sec} !== 17'd0) begin
            n_err++;
            $display("FAIL midnight: got %0d:%0d:%0d expected 0:0:0", hr, min, sec);
        end
    endtask

    task automatic test_set_mode();
        do_reset();
        repeat (30) step();
        press_mode();
        n_vec++;
        if ({state, tick} !== {2'd1, 1'b0}) begin
            n_err++;
            $display("FAIL enter_set_hr: got st=%0d tick=%0b expected 1/0", state, tick);
        end
        repeat (25) press_inc();
        n_vec++;
        if (hr !== 5'd1) begin
            n_err++;
            $display("FAIL hr_wrap: got hr=%0d expected 1", hr);
        end
        press_mode();
        n_vec++;
        if (state !== 2'd2) begin
            n_err++;
            $display("FAIL enter_set_min: got st=%0d expected 2", state);
        end
        repeat (60) press_inc();
        n_vec++;
        if ({hr, min, sec, tick} !== {5'd1, 6'd0, 6'd1, 1'b0}) begin
            n_err++;
            $display("FAIL min_wrap: got %0d:%0d:%0d tick=%0b expected 1:0:1 tick 0",
                     hr, min, sec, tick);
        end
        press_mode();
        n_vec++;
        if ({state, sec} !== {2'd0, 6'd0}) begin
            n_err++;
            $display("FAIL exit_set: got st=%0d sec=%0d expected 0/0", state, sec);
        end
        // inc_btn in RUN is ignored; this is also edge 1 of the new second
        inc_btn = 1'b1;
        step();
        inc_btn = 1'b0;
        n_vec++;
        if ({hr, min} !== {5'd1, 6'd0}) begin
            n_err++;
            $display("FAIL inc_in_run: got %0d:%0d expected 1:0", hr, min);
        end
        for (int k = 2; k <= 24; k++) begin
            step();
            n_vec++;
            if (tick !== (k == 24)) begin
                n_err++;
                $display("FAIL restart_tick: edge %0d got tick=%0b expected %0b",
                         k, tick, (k == 24));
            end
        end
        step();
        n_vec++;
        if (sec !== 6'd1) begin
            n_err++;
            $display("FAIL restart_sec: got sec=%0d expected 1", sec);
        end
    endtask

    task automatic test_btn_priority();
        do_reset();
        repeat (3) step();
        mode_btn = 1'b1;
        inc_btn  = 1'b1;
        step();
        mode_btn = 1'b0;
        inc_btn  = 1'b0;
        n_vec++;
        if ({state, hr} !== {2'd1, 5'd0}) begin
            n_err++;
            $display("FAIL mode_inc_run: got st=%0d hr=%0d expected 1/0", state, hr);
        end
        press_inc();
        mode_btn = 1'b1;
        inc_btn  = 1'b1;
        step();
        mode_btn = 1'b0;
        inc_btn  = 1'b0;
        n_vec++;
        if ({state, hr, min} !== {2'd2, 5'd1, 6'd0}) begin
            n_err++;
            $display("FAIL mode_inc_sethr: got st=%0d %0d:%0d expected 2 1:0", state, hr, min);
        end
        repeat (3) press_inc();
        n_vec++;
        if (min !== 6'd3) begin
            n_err++;
            $display("FAIL set_min3: got min=%0d expected 3", min);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_vec++;
        if ({state, hr, min, sec, tick} !== 20'd0) begin
            n_err++;
            $display("FAIL reset_in_set: got st=%0d %0d:%0d:%0d tick=%0b expected all 0",
                     state, hr, min, sec, tick);
        end
    endtask

`ifdef RTC_CONTROLLER_ALARM_EN
    task automatic test_alarm(input logic arm, input int exp_pulses);
        int pulses;
        int at_edge;
        alarm_hr  = 5'd0;
        alarm_min = 6'd1;
        alarm_arm = arm;
        pulses    = 0;
        at_edge   = -1;
        do_reset();
        n_vec++;
        if (alarm !== 1'b0) begin
            n_err++;
            $display("FAIL alarm_reset: got %0b expected 0", alarm);
        end
        repeat (58 * CLK_DIV) step();
        // 00:00:58 now; 00:01:00 appears after edge 2*CLK_DIV from here
        for (int k = 1; k <= 3 * CLK_DIV; k++) begin
            step();
            if (alarm === 1'b1) begin
                pulses++;
                at_edge = k;
            end
        end
        n_vec++;
        if (pulses !== exp_pulses) begin
            n_err++;
            $display("FAIL alarm_count arm=%0b: got %0d pulses expected %0d",
                     arm, pulses, exp_pulses);
        end
        if (arm) begin
            n_vec++;
            if (at_edge !== 2 * CLK_DIV) begin
                n_err++;
                $display("FAIL alarm_edge: got edge %0d expected %0d", at_edge, 2 * CLK_DIV);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_tick_period();
        test_rollover();
        test_set_mode();
        test_btn_priority();
`ifdef RTC_CONTROLLER_ALARM_EN
        test_alarm(1'b1, 1);
        test_alarm(1'b0, 0);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
